key_conditioner: RTL
====================

# key_conditioner

Input conditioning stage that sits directly upstream of the `OnBoard` egg-timer top level and turns raw push-button levels into clean, clock-aligned control signals. Each key passes through three steps:
- a two-flop synchronizer;
- a counter-based debouncer;
- an edge detector producing single-cycle press and release pulses.

Selected keys also generate hold-to-repeat pulses, so that holding KEY[1] steps the set time. The block replaces direct wiring of board keys into the timer logic.

## Interface
Parameters:
- N_KEYS, 3, number of independent key channels.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a level change; minimum 2. Board build uses 500000.
- REPEAT_EN, 3'b010, per-key mask (N_KEYS wide); 1 enables hold-to-repeat on that key.
- REPEAT_DELAY, 32, cycles from the PRESS pulse to the first REPEAT pulse; minimum 2.
- REPEAT_PERIOD, 8, cycles between subsequent REPEAT pulses; minimum 2.
- ACTIVE_LOW_IN, 0, when 1 the raw input is inverted at entry, so that 0 means pressed.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY_RAW  input  N_KEYS  raw key levels, asynchronous to CLK; 1 = pressed after optional inversion.
- KEY_LEVEL  output  N_KEYS  debounced pressed level per key.
- KEY_PRESS  output  N_KEYS  one-cycle pulse on each accepted 0→1 of KEY_LEVEL.
- KEY_RELEASE  output  N_KEYS  one-cycle pulse on each accepted 1→0 of KEY_LEVEL.
- KEY_REPEAT  output  N_KEYS  one-cycle auto-repeat pulse while a repeat-enabled key is held.

## Operation
Reset:
- RESET_N low clears, asynchronously:
  - all synchronizer flops, stable levels and counters;
  - all outputs.
- Every output reads 0 during reset and on the first cycle after it.

Per-channel datapath, with identical channels and no cross-channel interaction:
- Synchronizer: s1 ← KEY_RAW[i] (after optional inversion), then s ← s1.
- Debounce counter, width clog2(DEBOUNCE_CYCLES):
  - s equal to the stable level → counter cleared to 0.
  - s differs and counter < DEBOUNCE_CYCLES−1 → counter increments.
  - s differs and counter == DEBOUNCE_CYCLES−1 → stable ← s and counter ← 0, on the same edge.
- KEY_LEVEL is the stable register itself.
- KEY_PRESS / KEY_RELEASE are registered and assert on the same edge that stable changes, 1→ / 0→ respectively. Each is high for exactly one cycle.
- Repeat state machine, present only where REPEAT_EN[i] = 1; a channel with the bit at 0 holds KEY_REPEAT[i] at 0 permanently:
  - IDLE: waits for the stable level to rise, i.e. the KEY_PRESS edge. At that edge it loads the counter with 0 and goes to DELAY.
  - DELAY: counter increments each cycle. At count REPEAT_DELAY−1 it pulses KEY_REPEAT, clears the counter and goes to PERIOD.
  - PERIOD: counter increments each cycle. At count REPEAT_PERIOD−1 it pulses KEY_REPEAT, clears the counter and stays in PERIOD.
  - Any state: the stable level falling goes to IDLE on that same edge, and no REPEAT pulse is emitted on that edge.
- KEY_PRESS and KEY_REPEAT never assert in the same cycle.

## Timing
Raw-input latency:
- Let E0 be the first rising edge at which s1 samples the new raw level.
- KEY_LEVEL and the PRESS/RELEASE pulse change at edge E0+DEBOUNCE_CYCLES+1.
- Latency is the same for press and release.

Glitch rejection:
- A raw change lasting fewer than DEBOUNCE_CYCLES cycles at s produces no output activity.
- Any return of s to the stable value clears the counter; there is no partial credit.

Repeat timing:
- The first REPEAT pulse comes REPEAT_DELAY edges after the PRESS edge.
- Subsequent pulses are every REPEAT_PERIOD edges.

Key held through reset release:
- It is seen as a fresh press.
- PRESS appears DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge.

Reset asserted mid-debounce or mid-repeat:
- Everything aborts.
- No pulse is emitted on, or after, reset deassertion unless re-qualified.

Simultaneous changes on several keys are handled independently, each with its own latency.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, ACTIVE_LOW_IN=0.
- Clean press: KEY_RAW[0]=1 first sampled at E0 and held → KEY_LEVEL[0] rises and KEY_PRESS[0] is high for exactly one cycle at E5. KEY_REPEAT[0] stays 0 because its mask bit is 0.
- Bounce: KEY_RAW[2] pulses high for 3 cycles, low for 1, high for 3 → no change on any output. Then held high → PRESS at 5 edges after the last rising sample.
- Release: after the clean press, KEY_RAW[0]=0 first sampled at E0 → KEY_RELEASE[0] one-cycle pulse at E5 and KEY_LEVEL[0]=0.
- Repeat: KEY_RAW[1] held, with PRESS at edge P →
  - KEY_REPEAT[1] pulses at P+8, P+11, P+14;
  - raw released so the level falls at P+16 → no further pulses, and the next press restarts the DELAY count.
- Reset mid-operation: KEY[1] held, RESET_N pulled low between P+9 and P+10, held low for 3 cycles, then released with the key still held →
  - all outputs 0 immediately;
  - new PRESS 5 edges after the first post-reset sample;
  - first REPEAT 8 edges after that PRESS.
- Inverted input: ACTIVE_LOW_IN=1, KEY_RAW=3'b111 idle → all outputs 0. KEY_RAW[0]=0 held → PRESS[0] at E5.

Source files
------------

// File: rtl/key_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_conditioner
//
// Turns raw, asynchronous push-button levels into clean, clock-aligned control
// signals for the egg-timer top level. Every key channel is independent:
//   raw -> optional inversion -> two-flop synchronizer -> counter debouncer
//       -> registered press/release pulses -> optional hold-to-repeat pulses.
//
// Ports
//   CLK          system clock, all state updates on the rising edge
//   RESET_N      asynchronous active-low reset, clears every flop and output
//   KEY_RAW      raw key levels (1 = pressed after optional inversion)
//   KEY_LEVEL    debounced pressed level per key
//   KEY_PRESS    one-cycle pulse when KEY_LEVEL rises
//   KEY_RELEASE  one-cycle pulse when KEY_LEVEL falls
//   KEY_REPEAT   one-cycle auto-repeat pulse while a repeat-enabled key is held
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int                N_KEYS          = 3,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter logic [N_KEYS-1:0] REPEAT_EN       = 3'b010,
    parameter int                REPEAT_DELAY    = 32,
    parameter int                REPEAT_PERIOD   = 8,
    parameter bit                ACTIVE_LOW_IN   = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY_RAW,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_REPEAT
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // One repeat counter serves both the initial delay and the period, so it
    // is sized for whichever of the two is longer.
    localparam int              RP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                             : REPEAT_PERIOD;
    localparam int              RP_W        = $clog2(RP_MAX);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_e;

    logic [N_KEYS-1:0] raw_in;
    assign raw_in = ACTIVE_LOW_IN ? ~KEY_RAW : KEY_RAW;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic            s1;
        logic            s;
        logic            stable;
        logic            press_q;
        logic            release_q;
        logic [DB_W-1:0] db_cnt;
        logic            differs;
        logic            db_done;
        logic            rise;
        logic            fall;

        assign differs = (s != stable);
        // The level is accepted on the edge where the counter already holds
        // DEBOUNCE_CYCLES-1 and the synchronized sample still disagrees.
        assign db_done = differs && (db_cnt == DB_LAST);
        assign rise    = db_done && s;
        assign fall    = db_done && !s;

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others, which is what makes
        // s1 -> s a real two-stage synchronizer.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                s1        <= 1'b0;
                s         <= 1'b0;
                stable    <= 1'b0;
                db_cnt    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1        <= raw_in[i];
                s         <= s1;
                press_q   <= rise;
                release_q <= fall;
                // Any sample matching the stable level wipes the count: a
                // bounce earns no partial credit.
                if (!differs) begin
                    db_cnt <= '0;
                end else if (db_done) begin
                    stable <= s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign KEY_LEVEL[i]   = stable;
        assign KEY_PRESS[i]   = press_q;
        assign KEY_RELEASE[i] = release_q;

        if (REPEAT_EN[i]) begin : g_rpt
            rpt_state_e      state_q;
            rpt_state_e      state_d;
            logic [RP_W-1:0] rcnt_q;
            logic [RP_W-1:0] rcnt_d;
            logic            rep_q;
            logic            rep_d;

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    state_q <= RPT_IDLE;
                    rcnt_q  <= '0;
                    rep_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rcnt_q  <= rcnt_d;
                    rep_q   <= rep_d;
                end
            end

            // NOTE: every signal written here gets a default first, so no path
            // through the case statement can leave one unassigned and infer a
            // latch.
            always_comb begin
                state_d = state_q;
                rcnt_d  = rcnt_q;
                rep_d   = 1'b0;
                if (fall) begin
                    // Releasing the key wins over a repeat that would have
                    // fired on this same edge.
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end else begin
                    case (state_q)
                        RPT_IDLE: begin
                            if (rise) begin
                                state_d = RPT_DELAY;
                                rcnt_d  = '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (rcnt_q == DELAY_LAST) begin
                                rep_d   = 1'b1;
                                rcnt_d  = '0;
                                state_d = RPT_PERIOD;
                            end else begin
                                rcnt_d = rcnt_q + RP_W'(1);
                            end
                        end
                        RPT_PERIOD: begin
                            if (rcnt_q == PERIOD_LAST) begin
                                rep_d  = 1'b1;
                                rcnt_d = '0;
                            end else begin
                                rcnt_d = rcnt_q + RP_W'(1);
                            end
                        end
                        default: begin
                            state_d = RPT_IDLE;
                            rcnt_d  = '0;
                        end
                    endcase
                end
            end

            assign KEY_REPEAT[i] = rep_q;
        end else begin : g_no_rpt
            assign KEY_REPEAT[i] = 1'b0;
        end
    end

endmodule
